// File: rtl/fifoc2reg_if.sv
// Handshake and data bundle between the command-FIFO read port, the
// frame controller and the command register bank.
interface fifoc2reg_if #(
    parameter int unsigned REG_NUM = 9,
    parameter int unsigned LEN_W   = 12
);
    logic                 fs;
    logic                 fd;
    logic [LEN_W-1:0]     data_len;
    logic                 fifoc_rxen;
    logic [7:0]           fifoc_rxd;
    logic [REG_NUM*8-1:0] cmd_regs;
    logic                 cmd_vld;
    logic                 err;
    logic [1:0]           err_code;

    modport master (
        output fs, data_len, fifoc_rxd,
        input  fd, fifoc_rxen, cmd_regs, cmd_vld, err, err_code
    );

    modport slave (
        input  fs, data_len, fifoc_rxd,
        output fd, fifoc_rxen, cmd_regs, cmd_vld, err, err_code
    );
endinterface

// File: rtl/fifoc2reg.sv
// Command-frame parser: drains data_len bytes from the command FIFO, validates
// header/length/checksum and commits the payload to the command register bank.
module fifoc2reg #(
    parameter int unsigned REG_NUM = 9,
    parameter logic [15:0] HEAD    = 16'h55AA,
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned CHK_EN  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    fifoc2reg_if.slave io_bus
);
    localparam int unsigned      FL      = 2 + REG_NUM + CHK_EN;
    localparam logic [LEN_W-1:0] FL_L    = LEN_W'(FL);
    localparam logic [LEN_W-1:0] CHK_IDX = LEN_W'(2 + REG_NUM);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [1:0] {StIdle, StRead, StCheck, StDone} state_t;

    state_t               r_state;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     r_idx;
    logic                 r_rxen;
    logic                 r_cap;
    logic                 r_hdr_ok;
    logic [7:0]           r_sum;
    logic [7:0]           r_chk;
    logic [REG_NUM*8-1:0] r_shadow;
    logic [REG_NUM*8-1:0] r_cmd_regs;
    logic                 r_fd;
    logic                 r_cmd_vld;
    logic                 r_err;
    logic [1:0]           r_err_code;

    logic [7:0]       w_byte;
    logic [LEN_W-1:0] w_last_cnt;
    logic             w_len_err;
    logic             w_chk_err;

    assign w_byte     = io_bus.fifoc_rxd;
    // Stop compare against len-1 so len = 2^LEN_W-1 never needs a wider counter.
    assign w_last_cnt = r_len - ONE;
    assign w_len_err  = (r_len != FL_L);
    assign w_chk_err  = (CHK_EN != 0) && (r_sum != r_chk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rxen     <= 1'b0;
            r_cap      <= 1'b0;
            r_hdr_ok   <= 1'b0;
            r_sum      <= '0;
            r_chk      <= '0;
            r_shadow   <= '0;
            r_cmd_regs <= '0;
            r_fd       <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_cmd_vld <= 1'b0;
                    if (io_bus.fs) begin
                        r_len      <= io_bus.data_len;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_hdr_ok   <= 1'b1;
                        r_cap      <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                        if (io_bus.data_len == '0) begin
                            r_state <= StCheck;
                        end else begin
                            r_rxen  <= 1'b1;
                            r_state <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (r_rxen) begin
                        if (r_cnt == w_last_cnt) r_rxen <= 1'b0;
                        else                     r_cnt  <= r_cnt + ONE;
                    end
                    // FIFO data lags rxen by one clock.
                    r_cap <= r_rxen;
                    if (r_cap) begin
                        r_idx <= r_idx + ONE;
                        if (r_idx == '0 && w_byte != HEAD[15:8]) r_hdr_ok <= 1'b0;
                        if (r_idx == ONE && w_byte != HEAD[7:0]) r_hdr_ok <= 1'b0;
                        for (int j = 0; j < int'(REG_NUM); j++) begin
                            if (r_idx == LEN_W'(j + 2)) r_shadow[8*j +: 8] <= w_byte;
                        end
                        if (r_idx >= LEN_W'(2) && r_idx < CHK_IDX) r_sum <= r_sum + w_byte;
                        if (CHK_EN != 0 && r_idx == CHK_IDX) r_chk <= w_byte;
                        if (!r_rxen) r_state <= StCheck;
                    end
                end
                StCheck: begin
                    r_fd    <= 1'b1;
                    r_state <= StDone;
                    if (w_len_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                    end else if (!r_hdr_ok) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                    end else if (w_chk_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                    end else begin
                        r_cmd_regs <= r_shadow;
                        r_cmd_vld  <= 1'b1;
                    end
                end
                StDone: begin
                    r_cmd_vld <= 1'b0;
                    if (!io_bus.fs) begin
                        r_fd    <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.fd         = r_fd;
    assign io_bus.fifoc_rxen = r_rxen;
    assign io_bus.cmd_regs   = r_cmd_regs;
    assign io_bus.cmd_vld    = r_cmd_vld;
    assign io_bus.err        = r_err;
    assign io_bus.err_code   = r_err_code;
endmodule

// File: tb/tb_fifoc2reg.sv
// Directed bench for fifoc2reg: byte-FIFO model feeding hand-built frames,
// timing and register-bank results compared against hand-computed values.
module tb_fifoc2reg;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifoc2reg_if #(.REG_NUM(9), .LEN_W(12)) bus ();

    fifoc2reg #(
        .REG_NUM (9),
        .HEAD    (16'h55AA),
        .LEN_W   (12),
        .CHK_EN  (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] wr_ptr   = 8'd0;
    logic [7:0] rd_ptr   = 8'd0;
    logic       flush    = 1'b0;
    int         rxen_cnt = 0;
    int         vld_cnt  = 0;

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifoc_rxen) begin
            bus.fifoc_rxd <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
        if (bus.fifoc_rxen) rxen_cnt <= rxen_cnt + 1;
        if (bus.cmd_vld)    vld_cnt  <= vld_cnt + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    int         fd_cyc, reads, pulses, hold_low;
    logic       vld_at_fd, err_t1, fd_after;

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic push_frame(input logic [7:0] h1, input logic [7:0] base,
                              input logic [7:0] step, input logic [7:0] chk);
        push_byte(8'h55);
        push_byte(h1);
        for (int i = 0; i < 9; i++) push_byte(base + step * 8'(i));
        push_byte(chk);
    endtask

    // Raises fs (cycle T0), waits for fd, holds fs for hold extra clocks, drops fs.
    task automatic run_frame(input int len, input int hold);
        int rx0;
        int v0;
        @(posedge clk); #1;
        rx0           = rxen_cnt;
        v0            = vld_cnt;
        bus.fs        = 1'b1;
        bus.data_len  = 12'(len);
        fd_cyc        = -1;
        vld_at_fd     = 1'b0;
        hold_low      = 0;
        err_t1        = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 1) err_t1 = bus.err;
            if (bus.fd) begin
                fd_cyc    = k;
                vld_at_fd = bus.cmd_vld;
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!bus.fd) hold_low++;
        end
        bus.fs = 1'b0;
        @(posedge clk); #1;
        fd_after = bus.fd;
        reads    = rxen_cnt - rx0;
        pulses   = vld_cnt - v0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.fs       = 1'b0;
        bus.data_len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.fd !== 1'b0) $display("FAIL reset_fd: got %b want 0", bus.fd);
        else n_pass++;
        n_chk++; if (bus.fifoc_rxen !== 1'b0) $display("FAIL reset_rxen: got %b want 0", bus.fifoc_rxen);
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== 72'h0) $display("FAIL reset_regs: got %h want 0", bus.cmd_regs);
        else n_pass++;
        n_chk++; if ({bus.cmd_vld, bus.err, bus.err_code} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {bus.cmd_vld, bus.err, bus.err_code});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_valid();
        push_frame(8'hAA, 8'h01, 8'h01, 8'h2D);
        run_frame(12, 0);
        n_chk++; if (fd_cyc !== 15) $display("FAIL valid_fd_cycle: got %0d want 15", fd_cyc);
        else n_pass++;
        n_chk++; if (reads !== 12) $display("FAIL valid_reads: got %0d want 12", reads);
        else n_pass++;
        n_chk++; if (vld_at_fd !== 1'b1) $display("FAIL valid_vld_at_fd: got %b want 1", vld_at_fd);
        else n_pass++;
        n_chk++; if (pulses !== 1) $display("FAIL valid_vld_pulses: got %0d want 1", pulses);
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== 72'h090807060504030201)
            $display("FAIL valid_regs: got %h want 090807060504030201", bus.cmd_regs);
        else n_pass++;
        n_chk++; if ({bus.err, bus.err_code} !== 3'b000)
            $display("FAIL valid_err: got %b want 000", {bus.err, bus.err_code});
        else n_pass++;
        n_chk++; if (fd_after !== 1'b0) $display("FAIL valid_fd_drop: got %b want 0", fd_after);
        else n_pass++;
    endtask

    task automatic test_header();
        push_frame(8'hAB, 8'h11, 8'h01, 8'hBD);
        run_frame(12, 0);
        n_chk++; if ({bus.err, bus.err_code} !== 3'b110)
            $display("FAIL hdr_err: got %b want 110", {bus.err, bus.err_code});
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== 72'h090807060504030201)
            $display("FAIL hdr_regs_kept: got %h want 090807060504030201", bus.cmd_regs);
        else n_pass++;
        n_chk++; if (pulses !== 0 || vld_at_fd !== 1'b0)
            $display("FAIL hdr_no_vld: got %0d pulses want 0", pulses);
        else n_pass++;
        n_chk++; if (reads !== 12) $display("FAIL hdr_reads: got %0d want 12", reads);
        else n_pass++;
    endtask

    task automatic test_checksum();
        push_frame(8'hAA, 8'h01, 8'h01, 8'h2E);
        run_frame(12, 0);
        n_chk++; if ({bus.err, bus.err_code} !== 3'b111)
            $display("FAIL chk_err: got %b want 111", {bus.err, bus.err_code});
        else n_pass++;
        push_frame(8'hAA, 8'hFF, 8'h00, 8'hF7);
        run_frame(12, 0);
        n_chk++; if ({bus.err, bus.err_code} !== 3'b000)
            $display("FAIL chk_wrap_err: got %b want 000", {bus.err, bus.err_code});
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== {9{8'hFF}})
            $display("FAIL chk_wrap_regs: got %h want all FF", bus.cmd_regs);
        else n_pass++;
        n_chk++; if (pulses !== 1) $display("FAIL chk_wrap_vld: got %0d want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_length();
        push_frame(8'hAA, 8'h01, 8'h01, 8'h2D);
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE);
        run_frame(15, 0);
        n_chk++; if (reads !== 15) $display("FAIL len15_reads: got %0d want 15", reads);
        else n_pass++;
        n_chk++; if (fd_cyc !== 18) $display("FAIL len15_fd_cycle: got %0d want 18", fd_cyc);
        else n_pass++;
        n_chk++; if ({bus.err, bus.err_code} !== 3'b101)
            $display("FAIL len15_err: got %b want 101", {bus.err, bus.err_code});
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== {9{8'hFF}})
            $display("FAIL len15_regs_kept: got %h want all FF", bus.cmd_regs);
        else n_pass++;
        run_frame(0, 0);
        n_chk++; if (reads !== 0) $display("FAIL len0_reads: got %0d want 0", reads);
        else n_pass++;
        n_chk++; if (fd_cyc !== 2) $display("FAIL len0_fd_cycle: got %0d want 2", fd_cyc);
        else n_pass++;
        n_chk++; if ({bus.err, bus.err_code} !== 3'b101)
            $display("FAIL len0_err: got %b want 101", {bus.err, bus.err_code});
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        push_frame(8'hAA, 8'h21, 8'h01, 8'h4D);
        @(posedge clk); #1;
        bus.fs       = 1'b1;
        bus.data_len = 12'd12;
        repeat (5) @(posedge clk);
        #1;
        n_chk++; if (bus.fifoc_rxen !== 1'b1) $display("FAIL midrst_pre_rxen: got %b want 1", bus.fifoc_rxen);
        else n_pass++;
        rst_n  = 1'b0;
        bus.fs = 1'b0;
        #1;
        n_chk++; if ({bus.fifoc_rxen, bus.fd, bus.err} !== 3'b000)
            $display("FAIL midrst_ctrl: got %b want 000", {bus.fifoc_rxen, bus.fd, bus.err});
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== 72'h0) $display("FAIL midrst_regs: got %h want 0", bus.cmd_regs);
        else n_pass++;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (bus.fifoc_rxen !== 1'b0) $display("FAIL midrst_idle_rxen: got %b want 0", bus.fifoc_rxen);
        else n_pass++;
        push_frame(8'hAA, 8'h21, 8'h01, 8'h4D);
        run_frame(12, 0);
        n_chk++; if (bus.cmd_regs !== 72'h292827262524232221)
            $display("FAIL midrst_next_regs: got %h want 292827262524232221", bus.cmd_regs);
        else n_pass++;
        n_chk++; if ({bus.err, bus.err_code} !== 3'b000 || pulses !== 1)
            $display("FAIL midrst_next_ok: got err %b pulses %0d want 000/1",
                     {bus.err, bus.err_code}, pulses);
        else n_pass++;
    endtask

    task automatic test_fs_hold();
        push_frame(8'hAA, 8'h01, 8'h01, 8'h2E);
        run_frame(12, 20);
        n_chk++; if (fd_cyc !== 15) $display("FAIL hold_fd_cycle: got %0d want 15", fd_cyc);
        else n_pass++;
        n_chk++; if (hold_low !== 0) $display("FAIL hold_fd_stays: got %0d low cycles want 0", hold_low);
        else n_pass++;
        n_chk++; if (reads !== 12) $display("FAIL hold_no_retrigger: got %0d reads want 12", reads);
        else n_pass++;
        n_chk++; if (fd_after !== 1'b0) $display("FAIL hold_fd_drop: got %b want 0", fd_after);
        else n_pass++;
        n_chk++; if ({bus.err, bus.err_code} !== 3'b111)
            $display("FAIL hold_err_held: got %b want 111", {bus.err, bus.err_code});
        else n_pass++;
        push_frame(8'hAA, 8'h31, 8'h01, 8'hDD);
        run_frame(12, 0);
        n_chk++; if (err_t1 !== 1'b0) $display("FAIL hold_err_cleared: got %b want 0", err_t1);
        else n_pass++;
        n_chk++; if (bus.cmd_regs !== 72'h393837363534333231)
            $display("FAIL hold_second_regs: got %h want 393837363534333231", bus.cmd_regs);
        else n_pass++;
        n_chk++; if (pulses !== 1) $display("FAIL hold_second_vld: got %0d want 1", pulses);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_valid();
        test_header();
        test_checksum();
        test_length();
        test_reset_mid_read();
        test_fs_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
